// File: rtl/sfx_arbiter.sv
// Sound-effect scheduler: latches requests, grants the highest-priority pending
// effect to the sequence player, preempts after a hold time, drops stale requests.
module sfx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_BITS  = 4,
  parameter logic [N_REQ*ADDR_BITS-1:0] BASE_ADDRS = {4'd8, 4'd6, 4'd3, 4'd0},
  parameter int HOLD_TICKS = 4,
  parameter int MAX_WAIT   = 32,
  parameter int WAIT_BITS  = 6,
  localparam int ID_BITS   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 TICK,
  input  logic [N_REQ-1:0]     REQ,
  input  logic                 PLAYER_BUSY,
  input  logic                 PLAYER_DONE,
  output logic                 START,
  output logic [ADDR_BITS-1:0] START_ADDR,
  output logic                 ABORT,
  output logic                 ACTIVE,
  output logic [ID_BITS-1:0]   ACTIVE_ID,
  output logic [N_REQ-1:0]     DROPPED
);

  localparam logic [WAIT_BITS-1:0] HOLD_MAX = WAIT_BITS'(HOLD_TICKS);
  localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(MAX_WAIT);
  localparam logic [WAIT_BITS-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {IDLE, PLAY, ABORT_WAIT} state_t;

  state_t                 state, state_nxt;
  logic [N_REQ-1:0]       pend;
  logic [WAIT_BITS-1:0]   age [N_REQ];
  logic [WAIT_BITS-1:0]   hold;
  logic [ID_BITS-1:0]     grant_id;
  logic                   pend_any;
  logic                   granting;
  logic                   preempt;
  logic [N_REQ-1:0]       grant_vec;
  logic [N_REQ-1:0]       drop_vec;
  logic [N_REQ-1:0]       accept_vec;

  logic                   start_nxt;
  logic                   abort_nxt;
  logic                   active_nxt;
  logic [ADDR_BITS-1:0]   addr_nxt;
  logic [ID_BITS-1:0]     id_nxt;

  // Lowest pending index wins.
  always_comb begin
    grant_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend[i]) grant_id = ID_BITS'(i);
    end
  end

  assign pend_any = |pend;
  assign granting = (state == IDLE) && pend_any;
  assign preempt  = (state == PLAY) && !PLAYER_DONE && pend_any &&
                    (grant_id < ACTIVE_ID) && (hold == HOLD_MAX);

  always_comb begin
    grant_vec  = '0;
    drop_vec   = '0;
    accept_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_vec[i]  = granting && (grant_id == ID_BITS'(i));
      drop_vec[i]   = (MAX_WAIT != 0) && pend[i] && TICK && (age[i] == WAIT_MAX);
      accept_vec[i] = REQ[i] && !(ACTIVE && (ACTIVE_ID == ID_BITS'(i))) && !grant_vec[i];
    end
  end

  // Age restarts only when a request newly becomes pending; re-requests coalesce.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend    <= '0;
      DROPPED <= '0;
      for (int i = 0; i < N_REQ; i++) age[i] <= '0;
    end else begin
      DROPPED <= drop_vec & ~grant_vec;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_vec[i] || drop_vec[i]) begin
          pend[i] <= 1'b0;
        end else if (accept_vec[i]) begin
          pend[i] <= 1'b1;
        end
        if (accept_vec[i] && !pend[i]) begin
          age[i] <= '0;
        end else if (pend[i] && TICK && (age[i] != CNT_SAT)) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold <= '0;
    end else if (granting) begin
      hold <= '0;
    end else if ((state == PLAY) && TICK && (hold != HOLD_MAX)) begin
      hold <= hold + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (pend_any) state_nxt = PLAY;
      PLAY: begin
        if (PLAYER_DONE)  state_nxt = IDLE;
        else if (preempt) state_nxt = ABORT_WAIT;
      end
      ABORT_WAIT: if (!PLAYER_BUSY) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_nxt  = 1'b0;
    abort_nxt  = 1'b0;
    active_nxt = ACTIVE;
    addr_nxt   = START_ADDR;
    id_nxt     = ACTIVE_ID;
    case (state)
      IDLE: begin
        if (pend_any) begin
          start_nxt  = 1'b1;
          active_nxt = 1'b1;
          addr_nxt   = BASE_ADDRS[grant_id*ADDR_BITS +: ADDR_BITS];
          id_nxt     = grant_id;
        end
      end
      PLAY: begin
        if (PLAYER_DONE)  active_nxt = 1'b0;
        else if (preempt) abort_nxt  = 1'b1;
      end
      ABORT_WAIT: begin
        if (!PLAYER_BUSY) active_nxt = 1'b0;
      end
      default: active_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      START      <= 1'b0;
      ABORT      <= 1'b0;
      ACTIVE     <= 1'b0;
      START_ADDR <= '0;
      ACTIVE_ID  <= '0;
    end else begin
      START      <= start_nxt;
      ABORT      <= abort_nxt;
      ACTIVE     <= active_nxt;
      START_ADDR <= addr_nxt;
      ACTIVE_ID  <= id_nxt;
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Bench for sfx_arbiter: vector table of request patterns plus hand-built
// preemption, coalescing, drop, and reset sequences; START grants go through a scoreboard.
module tb_sfx_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TICK = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic       PLAYER_BUSY = 1'b0;
  logic       PLAYER_DONE = 1'b0;
  logic       START;
  logic [3:0] START_ADDR;
  logic       ABORT;
  logic       ACTIVE;
  logic [1:0] ACTIVE_ID;
  logic [3:0] DROPPED;

  int checks = 0;
  int errors = 0;
  bit monitorOn = 1'b0;

  typedef struct { int id; int addr; } start_exp_t;
  start_exp_t expQ[$];
  int baseTab[4] = '{0, 3, 6, 8};

  typedef struct { logic [3:0] req; int first; int second; } vec_t;
  vec_t vecs[6];

  sfx_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N), .TICK(TICK), .REQ(REQ),
    .PLAYER_BUSY(PLAYER_BUSY), .PLAYER_DONE(PLAYER_DONE),
    .START(START), .START_ADDR(START_ADDR), .ABORT(ABORT),
    .ACTIVE(ACTIVE), .ACTIVE_ID(ACTIVE_ID), .DROPPED(DROPPED)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expectStart(input int id);
    start_exp_t e;
    e.id = id;
    e.addr = baseTab[id];
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    REQ = r;
    step(1);
    REQ = 4'b0000;
  endtask

  task automatic pulseTick();
    TICK = 1'b1;
    step(1);
    TICK = 1'b0;
  endtask

  task automatic finishEffect();
    PLAYER_DONE = 1'b1;
    PLAYER_BUSY = 1'b0;
    step(1);
    PLAYER_DONE = 1'b0;
    checkOutput("active_after_done", ACTIVE, 0);
  endtask

  // Every START is matched against the next expected grant.
  always @(negedge CLK) begin
    if (monitorOn) begin
      checkOutput("start_abort_excl", int'(START & ABORT), 0);
      if (START) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_start: got id %0d addr %0d, expected no start at %0t",
                   ACTIVE_ID, START_ADDR, $time);
        end else begin
          start_exp_t e;
          e = expQ.pop_front();
          checkOutput("start_id", ACTIVE_ID, e.id);
          checkOutput("start_addr", START_ADDR, e.addr);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b0100, 2, -1};
    vecs[1] = '{4'b1010, 1, 3};
    vecs[2] = '{4'b0001, 0, -1};
    vecs[3] = '{4'b1000, 3, -1};
    vecs[4] = '{4'b0110, 1, 2};
    vecs[5] = '{4'b0011, 0, 1};

    step(2);
    checkOutput("reset_start", START, 0);
    checkOutput("reset_abort", ABORT, 0);
    checkOutput("reset_active", ACTIVE, 0);
    checkOutput("reset_id", ACTIVE_ID, 0);
    checkOutput("reset_addr", START_ADDR, 0);
    checkOutput("reset_dropped", DROPPED, 0);
    RESET_N = 1'b1;
    monitorOn = 1'b1;
    step(2);

    for (int v = 0; v < 6; v++) begin
      expectStart(vecs[v].first);
      if (vecs[v].second >= 0) expectStart(vecs[v].second);
      applyStimulus(vecs[v].req);
      checkOutput("start_not_early", START, 0);
      step(1);
      checkOutput("start_latency", START, 1);
      PLAYER_BUSY = 1'b1;
      step(3);
      checkOutput("active_held", ACTIVE, 1);
      checkOutput("addr_held", START_ADDR, baseTab[vecs[v].first]);
      finishEffect();
      if (vecs[v].second >= 0) begin
        checkOutput("idle_gap", START, 0);
        step(1);
        checkOutput("second_start", START, 1);
        PLAYER_BUSY = 1'b1;
        step(2);
        finishEffect();
      end
      step(2);
    end

    // Preemption of requester 3 by requester 0 after the hold time.
    expectStart(3);
    applyStimulus(4'b1000);
    step(1);
    checkOutput("pre_start3", START, 1);
    PLAYER_BUSY = 1'b1;
    pulseTick();
    expectStart(0);
    applyStimulus(4'b0001);
    for (int k = 2; k <= 4; k++) begin
      pulseTick();
      checkOutput("no_early_abort", ABORT, 0);
    end
    step(1);
    checkOutput("abort_pulse", ABORT, 1);
    step(1);
    checkOutput("abort_single", ABORT, 0);
    step(3);
    checkOutput("active_in_abort_wait", ACTIVE, 1);
    step(1);
    PLAYER_BUSY = 1'b0;
    step(1);
    checkOutput("abort_active_low", ACTIVE, 0);
    checkOutput("abort_idle_gap", START, 0);
    step(1);
    checkOutput("preempt_start", START, 1);
    PLAYER_BUSY = 1'b1;
    step(2);
    finishEffect();
    step(2);

    // Re-request of the active effect coalesces; lower priority waits.
    expectStart(2);
    applyStimulus(4'b0100);
    step(1);
    checkOutput("coal_start2", START, 1);
    PLAYER_BUSY = 1'b1;
    step(2);
    expectStart(3);
    applyStimulus(4'b1100);
    for (int k = 0; k < 6; k++) begin
      pulseTick();
      checkOutput("coal_no_abort", ABORT, 0);
    end
    finishEffect();
    checkOutput("coal_idle_gap", START, 0);
    step(1);
    checkOutput("coal_start3", START, 1);
    PLAYER_BUSY = 1'b1;
    step(2);
    finishEffect();
    step(6);
    checkOutput("coal_queue_empty", expQ.size(), 0);

    // Pending requester 1 times out behind a never-ending requester 0.
    expectStart(0);
    applyStimulus(4'b0001);
    step(1);
    checkOutput("drop_start0", START, 1);
    PLAYER_BUSY = 1'b1;
    applyStimulus(4'b0010);
    for (int k = 1; k <= 32; k++) begin
      pulseTick();
      checkOutput("no_early_drop", DROPPED, 0);
    end
    pulseTick();
    checkOutput("drop_pulse", DROPPED, 4'b0010);
    step(1);
    checkOutput("drop_single", DROPPED, 0);
    finishEffect();
    step(4);
    checkOutput("drop_no_restart", ACTIVE, 0);

    // PLAYER_DONE coincides with a valid preemption.
    expectStart(2);
    applyStimulus(4'b0100);
    step(1);
    checkOutput("race_start2", START, 1);
    PLAYER_BUSY = 1'b1;
    repeat (4) pulseTick();
    expectStart(0);
    applyStimulus(4'b0001);
    PLAYER_DONE = 1'b1;
    PLAYER_BUSY = 1'b0;
    step(1);
    PLAYER_DONE = 1'b0;
    checkOutput("race_no_abort", ABORT, 0);
    checkOutput("race_active_low", ACTIVE, 0);
    step(1);
    checkOutput("race_start0", START, 1);
    checkOutput("race_still_no_abort", ABORT, 0);
    PLAYER_BUSY = 1'b1;
    step(2);
    finishEffect();
    step(2);

    // Reset while waiting for an abort to complete.
    expectStart(3);
    applyStimulus(4'b1000);
    step(1);
    checkOutput("rst_start3", START, 1);
    PLAYER_BUSY = 1'b1;
    repeat (4) pulseTick();
    applyStimulus(4'b0010);
    step(1);
    checkOutput("rst_abort", ABORT, 1);
    step(1);
    checkOutput("rst_pre_id", ACTIVE_ID, 3);
    RESET_N = 1'b0;
    #1;
    checkOutput("rst_active", ACTIVE, 0);
    checkOutput("rst_id", ACTIVE_ID, 0);
    checkOutput("rst_addr", START_ADDR, 0);
    checkOutput("rst_abort_low", ABORT, 0);
    checkOutput("rst_start_low", START, 0);
    PLAYER_BUSY = 1'b0;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    step(6);
    checkOutput("rst_no_start", ACTIVE, 0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    monitorOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
